// File: rtl/alu_issue_pkg.sv
// Shared definitions for dual_alu_issue: entry/packet field positions, op codes,
// taken encodings, lane states and the ALU / forward-snoop helper functions.
package alu_issue_pkg;

    localparam int ENTRY_W = 57;
    localparam int PKT_W   = 23;
    localparam int DATA_W  = 16;
    localparam int ROB_W   = 6;

    localparam int E_VALID  = 56;
    localparam int E_OP_HI  = 55;
    localparam int E_OP_LO  = 52;
    localparam int E_ROB_HI = 51;
    localparam int E_ROB_LO = 46;
    localparam int E_LA_HI  = 45;
    localparam int E_LA_LO  = 40;
    localparam int E_LB_HI  = 39;
    localparam int E_LB_LO  = 34;
    localparam int E_VA_HI  = 33;
    localparam int E_VA_LO  = 18;
    localparam int E_VB_HI  = 17;
    localparam int E_VB_LO  = 2;
    localparam int E_PEND_A = 1;
    localparam int E_PEND_B = 0;

    localparam int P_VALID  = 22;
    localparam int P_ROB_HI = 21;
    localparam int P_ROB_LO = 16;
    localparam int P_VAL_HI = 15;
    localparam int P_VAL_LO = 0;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_MUL = 4'd7;
    localparam logic [3:0] OP_MOV = 4'd8;

    localparam logic [1:0] TAKEN_NONE = 2'b00;
    localparam logic [1:0] TAKEN_HEAD = 2'b01;
    localparam logic [1:0] TAKEN_BOTH = 2'b10;

    typedef enum logic {
        LANE_IDLE = 1'b0,
        LANE_BUSY = 1'b1
    } lane_state_e;

    function automatic logic [15:0] alu_result(input logic [3:0] op,
                                               input logic [15:0] a,
                                               input logic [15:0] b);
        logic [15:0] r;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SHL:  r = a << b[3:0];
            OP_SHR:  r = a >> b[3:0];
            OP_MUL:  r = a * b;
            OP_MOV:  r = a;
            default: r = 16'h0000;
        endcase
        return r;
    endfunction

    // Returns {hit, value}; bus A has the highest priority, D the lowest.
    function automatic logic [16:0] snoop(input logic [5:0]  look,
                                          input logic [22:0] fa,
                                          input logic [22:0] fb,
                                          input logic [22:0] fc,
                                          input logic [22:0] fd);
        logic [16:0] r;
        if (fa[P_VALID] && (fa[P_ROB_HI:P_ROB_LO] == look)) begin
            r = {1'b1, fa[P_VAL_HI:P_VAL_LO]};
        end else if (fb[P_VALID] && (fb[P_ROB_HI:P_ROB_LO] == look)) begin
            r = {1'b1, fb[P_VAL_HI:P_VAL_LO]};
        end else if (fc[P_VALID] && (fc[P_ROB_HI:P_ROB_LO] == look)) begin
            r = {1'b1, fc[P_VAL_HI:P_VAL_LO]};
        end else if (fd[P_VALID] && (fd[P_ROB_HI:P_ROB_LO] == look)) begin
            r = {1'b1, fd[P_VAL_HI:P_VAL_LO]};
        end else begin
            r = 17'd0;
        end
        return r;
    endfunction

endpackage

// File: rtl/dual_alu_issue_if.sv
// Queue-head / forward-bus bundle between the instruction queue and dual_alu_issue.
interface dual_alu_issue_if;
    import alu_issue_pkg::*;

    logic [ENTRY_W-1:0] inOperation0;
    logic [ENTRY_W-1:0] inOperation1;
    logic [PKT_W-1:0]   forwardA;
    logic [PKT_W-1:0]   forwardB;
    logic [PKT_W-1:0]   forwardC;
    logic [PKT_W-1:0]   forwardD;
    logic [1:0]         taken;
    logic [PKT_W-1:0]   forwardOut0;
    logic [PKT_W-1:0]   forwardOut1;

    modport master (
        output inOperation0, inOperation1,
        output forwardA, forwardB, forwardC, forwardD,
        input  taken, forwardOut0, forwardOut1
    );

    modport slave (
        input  inOperation0, inOperation1,
        input  forwardA, forwardB, forwardC, forwardD,
        output taken, forwardOut0, forwardOut1
    );
endinterface

// File: rtl/alu_lane.sv
// One ALU lane: single-cycle ops register their packet on the issue edge; MUL
// holds the lane BUSY and emits MUL_LATENCY-1 edges after issue.
module alu_lane
    import alu_issue_pkg::*;
#(
    parameter int MUL_LATENCY = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              issue,
    input  logic [3:0]        op,
    input  logic [ROB_W-1:0]  rob,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              idle,
    output logic [PKT_W-1:0]  packet
);

    localparam logic [3:0] CNT_LOAD = 4'(MUL_LATENCY - 1);

    lane_state_e       state_r;
    lane_state_e       next_state_s;
    logic [3:0]        cnt_r;
    logic [ROB_W-1:0]  rob_r;
    logic [DATA_W-1:0] prod_r;
    logic [PKT_W-1:0]  packet_r;
    logic              clear_s;
    logic              is_mul_s;
    logic              done_s;

    assign clear_s  = reset | flush;
    assign is_mul_s = issue & (op == OP_MUL);
    assign done_s   = (state_r == LANE_BUSY) & (cnt_r == 4'd1);

    // State register
    always_ff @(posedge clk) begin
        if (clear_s) begin
            state_r <= LANE_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            LANE_IDLE: begin
                if (is_mul_s) begin
                    next_state_s = LANE_BUSY;
                end else begin
                    next_state_s = LANE_IDLE;
                end
            end
            LANE_BUSY: begin
                if (done_s) begin
                    next_state_s = LANE_IDLE;
                end else begin
                    next_state_s = LANE_BUSY;
                end
            end
            default: next_state_s = LANE_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        idle = 1'b0;
        case (state_r)
            LANE_IDLE: idle = 1'b1;
            LANE_BUSY: idle = 1'b0;
            default:   idle = 1'b0;
        endcase
    end

    // MUL countdown and held result; the product is formed at issue time
    always_ff @(posedge clk) begin
        if (clear_s) begin
            cnt_r  <= 4'd0;
            rob_r  <= '0;
            prod_r <= '0;
        end else if (is_mul_s) begin
            cnt_r  <= CNT_LOAD;
            rob_r  <= rob;
            prod_r <= alu_result(op, a, b);
        end else if ((state_r == LANE_BUSY) && (cnt_r != 4'd0)) begin
            cnt_r <= cnt_r - 4'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Result packet, valid for exactly one cycle
    always_ff @(posedge clk) begin
        if (clear_s) begin
            packet_r <= '0;
        end else if (issue && !is_mul_s) begin
            packet_r <= {1'b1, rob, alu_result(op, a, b)};
        end else if (done_s) begin
            packet_r <= {1'b1, rob_r, prod_r};
        end else begin
            packet_r <= '0;
        end
    end

    assign packet = packet_r;

endmodule

// File: rtl/dual_alu_issue.sv
// In-order dual-lane issue stage consuming the two queue head entries.
// Optional macro ISSUE_BYPASS_EN lets pending operands be satisfied from forward buses.
module dual_alu_issue
    import alu_issue_pkg::*;
#(
    parameter int MUL_LATENCY = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    dual_alu_issue_if.slave bus
);

    logic [ENTRY_W-1:0] entry_s [2];
    logic [DATA_W-1:0]  op_a_s  [2];
    logic [DATA_W-1:0]  op_b_s  [2];
    logic               ready_s [2];
    logic               lane_idle_s [2];
    logic               take0_s;
    logic               take1_s;

    assign entry_s[0] = bus.inOperation0;
    assign entry_s[1] = bus.inOperation1;

`ifdef ISSUE_BYPASS_EN
    logic [16:0] hit_a_s [2];
    logic [16:0] hit_b_s [2];

    // Operand resolution: a pending operand is replaced by the matching bus value
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            hit_a_s[k] = snoop(entry_s[k][E_LA_HI:E_LA_LO], bus.forwardA, bus.forwardB,
                               bus.forwardC, bus.forwardD);
            hit_b_s[k] = snoop(entry_s[k][E_LB_HI:E_LB_LO], bus.forwardA, bus.forwardB,
                               bus.forwardC, bus.forwardD);
            if (entry_s[k][E_PEND_A]) begin
                op_a_s[k] = hit_a_s[k][15:0];
            end else begin
                op_a_s[k] = entry_s[k][E_VA_HI:E_VA_LO];
            end
            if (entry_s[k][E_PEND_B]) begin
                op_b_s[k] = hit_b_s[k][15:0];
            end else begin
                op_b_s[k] = entry_s[k][E_VB_HI:E_VB_LO];
            end
            ready_s[k] = entry_s[k][E_VALID]
                       & (~entry_s[k][E_PEND_A] | hit_a_s[k][16])
                       & (~entry_s[k][E_PEND_B] | hit_b_s[k][16]);
        end
    end
`else
    logic unused_s;
    assign unused_s = ^{bus.forwardA, bus.forwardB, bus.forwardC, bus.forwardD,
                        entry_s[0][E_LA_HI:E_LB_LO], entry_s[1][E_LA_HI:E_LB_LO]};

    // Operand resolution: only entries with no pending operand are ready
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            op_a_s[k]  = entry_s[k][E_VA_HI:E_VA_LO];
            op_b_s[k]  = entry_s[k][E_VB_HI:E_VB_LO];
            ready_s[k] = entry_s[k][E_VALID]
                       & ~entry_s[k][E_PEND_A] & ~entry_s[k][E_PEND_B];
        end
    end
`endif

    // Lane 1 may only take head+1 when lane 0 takes the head in the same cycle
    assign take0_s = ready_s[0] & lane_idle_s[0] & ~flush & ~reset;
    assign take1_s = take0_s & ready_s[1] & lane_idle_s[1];

    // Taken encoding
    always_comb begin
        if (take1_s) begin
            bus.taken = TAKEN_BOTH;
        end else if (take0_s) begin
            bus.taken = TAKEN_HEAD;
        end else begin
            bus.taken = TAKEN_NONE;
        end
    end

    alu_lane #(.MUL_LATENCY(MUL_LATENCY)) u_lane0 (
        .clk    (clk),
        .reset  (reset),
        .flush  (flush),
        .issue  (take0_s),
        .op     (entry_s[0][E_OP_HI:E_OP_LO]),
        .rob    (entry_s[0][E_ROB_HI:E_ROB_LO]),
        .a      (op_a_s[0]),
        .b      (op_b_s[0]),
        .idle   (lane_idle_s[0]),
        .packet (bus.forwardOut0)
    );

    alu_lane #(.MUL_LATENCY(MUL_LATENCY)) u_lane1 (
        .clk    (clk),
        .reset  (reset),
        .flush  (flush),
        .issue  (take1_s),
        .op     (entry_s[1][E_OP_HI:E_OP_LO]),
        .rob    (entry_s[1][E_ROB_HI:E_ROB_LO]),
        .a      (op_a_s[1]),
        .b      (op_b_s[1]),
        .idle   (lane_idle_s[1]),
        .packet (bus.forwardOut1)
    );

endmodule

// File: tb/tb_dual_alu_issue.sv
// Self-checking bench for dual_alu_issue: directed steps, then a randomized queue
// checked against a cycle-level behavioural model of issue and lane timing.
module tb_dual_alu_issue;
    import alu_issue_pkg::*;

    localparam int LAT = 3;

    logic clk = 1'b0;
    logic reset;
    logic flush;

    dual_alu_issue_if bus();

    dual_alu_issue #(.MUL_LATENCY(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;
    logic [56:0] q[$];
    logic [22:0] fw [4];
    bit          pend_v [2];
    int          pend_edge [2];
    logic [22:0] pend_pkt [2];
    logic [22:0] exp_o [2];
    logic [1:0]  taken_seen;
    bit          auto_wake = 1'b0;

    task automatic chk(input string tag, input logic [22:0] obs, input logic [22:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [56:0] mk(input int v, input int op, input int rob, input int la,
                                       input int lb, input int a, input int b, input int user);
        logic [56:0] e;
        e = '0;
        e[56]    = v[0];
        e[55:52] = op[3:0];
        e[51:46] = rob[5:0];
        e[45:40] = la[5:0];
        e[39:34] = lb[5:0];
        e[33:18] = a[15:0];
        e[17:2]  = b[15:0];
        e[1:0]   = user[1:0];
        return e;
    endfunction

    function automatic int ref_alu(input int op, input int a, input int b);
        int r;
        case (op)
            0: r = a + b;
            1: r = a - b;
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = a << (b % 16);
            6: r = a >> (b % 16);
            7: r = a * b;
            8: r = a;
            default: r = 0;
        endcase
        return r & 32'hFFFF;
    endfunction

`ifdef ISSUE_BYPASS_EN
    // First matching bus in A..D order, or -1
    function automatic int bus_val(input logic [5:0] look);
        int v;
        v = -1;
        for (int i = 3; i >= 0; i--) begin
            if (fw[i][22] && fw[i][21:16] == look) v = int'(fw[i][15:0]);
        end
        return v;
    endfunction
`endif

    function automatic bit resolve(input logic [56:0] e, output int a, output int b);
        bit ok;
        ok = e[56];
        a  = int'(e[33:18]);
        b  = int'(e[17:2]);
`ifdef ISSUE_BYPASS_EN
        if (e[1]) begin
            a = bus_val(e[45:40]);
            if (a < 0) ok = 1'b0;
        end
        if (e[0]) begin
            b = bus_val(e[39:34]);
            if (b < 0) ok = 1'b0;
        end
`else
        if (e[1:0] != 2'b00) ok = 1'b0;
`endif
        return ok;
    endfunction

    task automatic model_issue(input int l, input logic [56:0] e, input int a, input int b);
        logic [22:0] pkt;
        pkt = {1'b1, e[51:46], 16'(ref_alu(int'(e[55:52]), a, b))};
        if (e[55:52] == 4'd7) begin
            pend_v[l]    = 1'b1;
            pend_edge[l] = edge_n + LAT - 1;
            pend_pkt[l]  = pkt;
        end else begin
            exp_o[l] = pkt;
        end
    endtask

    // One clock cycle: drive at negedge, check taken, clock, check packets
    task automatic cycle(input bit rst, input bit fl);
        logic [56:0] e0, e1;
        int a0, b0, a1, b1;
        bit r0, r1, t0, t1;
        logic [1:0] exp_t;
        e0 = (q.size() > 0) ? q[0] : '0;
        e1 = (q.size() > 1) ? q[1] : '0;
        bus.inOperation0 = e0;
        bus.inOperation1 = e1;
        bus.forwardA = fw[0];
        bus.forwardB = fw[1];
        bus.forwardC = fw[2];
        bus.forwardD = fw[3];
        reset = rst;
        flush = fl;
        #1;
        r0 = resolve(e0, a0, b0);
        r1 = resolve(e1, a1, b1);
        t0 = r0 && !pend_v[0] && !rst && !fl;
        t1 = t0 && r1 && !pend_v[1];
        exp_t = t1 ? 2'b10 : (t0 ? 2'b01 : 2'b00);
        taken_seen = bus.taken;
        chk("taken", {21'd0, bus.taken}, {21'd0, exp_t});
        @(posedge clk);
        edge_n++;
        exp_o[0] = '0;
        exp_o[1] = '0;
        if (rst || fl) begin
            pend_v[0] = 1'b0;
            pend_v[1] = 1'b0;
        end else begin
            for (int l = 0; l < 2; l++) begin
                if (pend_v[l] && pend_edge[l] == edge_n) begin
                    exp_o[l]  = pend_pkt[l];
                    pend_v[l] = 1'b0;
                end
            end
            if (t0) model_issue(0, e0, a0, b0);
            if (t1) model_issue(1, e1, a1, b1);
        end
        #1;
        chk("out0", bus.forwardOut0, exp_o[0]);
        chk("out1", bus.forwardOut1, exp_o[1]);
        if (t1) begin
            void'(q.pop_front());
            void'(q.pop_front());
        end else if (t0) begin
            void'(q.pop_front());
        end
        if (auto_wake) begin
            foreach (q[i]) begin
                if (q[i][1:0] != 2'b00 && $urandom_range(2) == 0) q[i][1:0] = 2'b00;
            end
            if (q.size() > 0 && !q[0][56] && $urandom_range(1) == 0) q[0][56] = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) fw[i] = '0;
        pend_v[0] = 1'b0;
        pend_v[1] = 1'b0;
        @(negedge clk);

        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        chk("reset_out0", bus.forwardOut0, 23'd0);
        chk("reset_out1", bus.forwardOut1, 23'd0);

        // ADD wraps into the sign bit; head+1 invalid
        q.push_back(mk(1, 0, 5, 0, 0, 16'h7FFF, 16'h0001, 0));
        q.push_back(mk(0, 0, 6, 0, 0, 1, 1, 0));
        cycle(1'b0, 1'b0);
        chk("add_taken", {21'd0, taken_seen}, 23'd1);
        chk("add_out0", bus.forwardOut0, {1'b1, 6'd5, 16'h8000});
        cycle(1'b0, 1'b0);
        chk("invalid_taken", {21'd0, taken_seen}, 23'd0);
        q.delete();

        // Dual issue SUB + XOR
        q.push_back(mk(1, 1, 1, 0, 0, 3, 5, 0));
        q.push_back(mk(1, 4, 2, 0, 0, 16'hFF00, 16'h0FF0, 0));
        cycle(1'b0, 1'b0);
        chk("dual_taken", {21'd0, taken_seen}, 23'd2);
        chk("sub_out0", bus.forwardOut0, {1'b1, 6'd1, 16'hFFFE});
        chk("xor_out1", bus.forwardOut1, {1'b1, 6'd2, 16'hF0F0});

        // MUL blocks lane 0, then an ADD follows
        q.push_back(mk(1, 7, 9, 0, 0, 16'h0100, 16'h0101, 0));
        cycle(1'b0, 1'b0);
        q.push_back(mk(1, 0, 3, 0, 0, 1, 2, 0));
        cycle(1'b0, 1'b0);
        chk("mul_busy1", {21'd0, taken_seen}, 23'd0);
        cycle(1'b0, 1'b0);
        chk("mul_busy2", {21'd0, taken_seen}, 23'd0);
        chk("mul_out0", bus.forwardOut0, {1'b1, 6'd9, 16'h0100});
        cycle(1'b0, 1'b0);
        chk("after_mul_taken", {21'd0, taken_seen}, 23'd1);
        chk("after_mul_out0", bus.forwardOut0, {1'b1, 6'd3, 16'h0003});

        // head+1 with B pending waits until its operand arrives
        q.push_back(mk(1, 0, 10, 0, 0, 4, 4, 0));
        q.push_back(mk(1, 8, 11, 0, 0, 16'h1234, 0, 1));
        cycle(1'b0, 1'b0);
        chk("pend_taken", {21'd0, taken_seen}, 23'd1);
        cycle(1'b0, 1'b0);
        chk("pend_wait", {21'd0, taken_seen}, 23'd0);
        q[0][1:0] = 2'b00;
        cycle(1'b0, 1'b0);
        chk("pend_go", {21'd0, taken_seen}, 23'd1);
        chk("pend_out0", bus.forwardOut0, {1'b1, 6'd11, 16'h1234});

        // Flush kills an in-flight MUL
        q.push_back(mk(1, 7, 20, 0, 0, 7, 9, 0));
        cycle(1'b0, 1'b0);
        q.push_back(mk(1, 2, 21, 0, 0, 16'hF0F0, 16'h00FF, 0));
        cycle(1'b0, 1'b1);
        chk("flush_taken", {21'd0, taken_seen}, 23'd0);
        chk("flush_out0", bus.forwardOut0, 23'd0);
        cycle(1'b0, 1'b0);
        chk("post_flush_taken", {21'd0, taken_seen}, 23'd1);
        chk("post_flush_out0", bus.forwardOut0, {1'b1, 6'd21, 16'h00F0});
        cycle(1'b0, 1'b0);
        chk("no_mul_out0", bus.forwardOut0, 23'd0);

        // Operand A pending, supplied by forwardC
        q.delete();
        q.push_back(mk(1, 0, 13, 12, 0, 99, 4, 2));
        fw[2] = {1'b1, 6'd12, 16'd10};
        cycle(1'b0, 1'b0);
`ifdef ISSUE_BYPASS_EN
        chk("bypass_taken", {21'd0, taken_seen}, 23'd1);
        chk("bypass_out0", bus.forwardOut0, {1'b1, 6'd13, 16'd14});
`else
        chk("bypass_taken", {21'd0, taken_seen}, 23'd0);
`endif
        q.delete();
        fw[2] = '0;

        // Randomized traffic
        auto_wake = 1'b1;
        for (int n = 0; n < 600; n++) begin
            while (q.size() < 3) begin
                q.push_back(mk(($urandom_range(9) != 0) ? 1 : 0,
                               ($urandom_range(3) == 0) ? 7 : int'($urandom_range(15)),
                               int'($urandom_range(63)), int'($urandom_range(7)),
                               int'($urandom_range(7)), int'($urandom_range(65535)),
                               int'($urandom_range(65535)),
                               ($urandom_range(2) == 0) ? int'($urandom_range(3)) : 0));
            end
            for (int i = 0; i < 4; i++) begin
                fw[i] = {1'($urandom_range(1)), 6'($urandom_range(7)), 16'($urandom_range(65535))};
            end
            cycle($urandom_range(49) == 0, $urandom_range(29) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
